// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - Host-side TX/RX byte FIFOs with send/receive handshakes to a UART core
module uart_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tx_push,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  output logic       tx_idle,
  input  logic       rx_pop,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       err_clr,
  output logic       tx_drop,
  output logic       rx_ovf,
  output logic [7:0] UART_TXD,
  output logic       TX_EN,
  input  logic       TX_STATUS,
  input  logic [7:0] UART_RXD,
  input  logic       RX_EFF,
  output logic       RX_READ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;
  tx_state_t state;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_cnt;
  logic [15:0]   busy_cnt;
  logic [7:0]    rx_hold;

  logic tx_pop, tx_wen, tx_rej, rx_deq, rx_wen, rx_lost, rx_cap;

  assign tx_full  = (tx_cnt == FULL);
  assign tx_idle  = (tx_cnt == '0) && (state == IDLE);
  assign rx_empty = (rx_cnt == '0);
  assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd];

  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  always_comb begin
    tx_pop  = (state == IDLE) && (tx_cnt != '0) && TX_STATUS;
    tx_wen  = tx_push && (!tx_full || tx_pop);
    tx_rej  = tx_push && !tx_wen;
    rx_deq  = rx_pop && !rx_empty;
    rx_wen  = RX_READ && ((rx_cnt != FULL) || rx_deq);
    rx_lost = RX_READ && !rx_wen;
    rx_cap  = RX_EFF && !RX_READ;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      if (tx_wen) tx_mem[tx_wr] <= tx_data;
      if (rx_wen) rx_mem[rx_wr] <= rx_hold;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_cnt   <= '0;
      busy_cnt <= '0;
      UART_TXD <= 8'h00;
      TX_EN    <= 1'b0;
      tx_drop  <= 1'b0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_cnt   <= '0;
      rx_hold  <= 8'h00;
      RX_READ  <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      TX_EN <= 1'b0;
      if (tx_wen) tx_wr <= tx_wr + AW'(1);
      if (tx_pop) tx_rd <= tx_rd + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_wen) - CW'(tx_pop);

      case (state)
        IDLE: begin
          if (tx_pop) begin
            UART_TXD <= tx_mem[tx_rd];
            TX_EN    <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        // Give up on a sender that never reports busy; the byte is not retried.
        WAIT_BUSY: begin
          if (!TX_STATUS) state <= WAIT_DONE;
          else if (busy_cnt == 16'hFFFE) state <= IDLE;
          else busy_cnt <= busy_cnt + 16'd1;
        end
        WAIT_DONE: begin
          if (TX_STATUS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (tx_rej) tx_drop <= 1'b1;
      else if (err_clr) tx_drop <= 1'b0;

      // The byte is latched at the acknowledge and enqueued one cycle later.
      RX_READ <= rx_cap;
      if (rx_cap) rx_hold <= UART_RXD;
      if (rx_wen) rx_wr <= rx_wr + AW'(1);
      if (rx_deq) rx_rd <= rx_rd + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_wen) - CW'(rx_deq);

      if (rx_lost) rx_ovf <= 1'b1;
      else if (err_clr) rx_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - Scoreboard bench for uart_fifo_ctrl with a behavioural UART sender/receiver
module tb_uart_fifo_ctrl;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_pop = 1'b0;
  logic       err_clr = 1'b0;
  logic       TX_STATUS = 1'b1;
  logic [7:0] UART_RXD = 8'h00;
  logic       RX_EFF = 1'b0;
  logic       tx_full, tx_idle, rx_empty, tx_drop, rx_ovf, TX_EN, RX_READ;
  logic [7:0] rx_data, UART_TXD;

  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         en_cyc[$];
  int         rx_read_count = 0;
  logic       prev_rx_read = 1'b0;
  int         uart_mode = 0;
  int         busy = 0;

  uart_fifo_ctrl #(.DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data),
    .tx_full(tx_full), .tx_idle(tx_idle), .rx_pop(rx_pop), .rx_data(rx_data),
    .rx_empty(rx_empty), .err_clr(err_clr), .tx_drop(tx_drop), .rx_ovf(rx_ovf),
    .UART_TXD(UART_TXD), .TX_EN(TX_EN), .TX_STATUS(TX_STATUS), .UART_RXD(UART_RXD),
    .RX_EFF(RX_EFF), .RX_READ(RX_READ)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic note(input string name, input bit ok, input string got, input string want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s", name, got, want);
  endtask
  task automatic chk_b(input string name, input logic act, input logic exp);
    note(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
  endtask
  task automatic chk_v(input string name, input logic [7:0] act, input logic [7:0] exp);
    note(name, act === exp, $sformatf("0x%02h", act), $sformatf("0x%02h", exp));
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    note(name, act == exp, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  // Sender model: mode 0 = 20-cycle busy after each TX_EN, 1 = held busy, 2 = stuck free.
  initial begin
    forever begin
      @(posedge sysclk); #2;
      if (uart_mode == 1) begin TX_STATUS = 1'b0; busy = 0; end
      else if (uart_mode == 2) begin TX_STATUS = 1'b1; busy = 0; end
      else if (TX_EN) begin TX_STATUS = 1'b0; busy = 20; end
      else if (busy > 0) begin busy--; TX_STATUS = (busy == 0); end
      else TX_STATUS = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a send or the host consumes a byte.
  always @(negedge sysclk) begin
    if (TX_EN === 1'b1) begin
      en_cyc.push_back(cyc);
      chk_b("tx_en_expected", tx_exp.size() != 0, 1'b1);
      if (tx_exp.size() != 0) chk_v("uart_txd", UART_TXD, tx_exp.pop_front());
    end
    if (RX_READ === 1'b1) begin
      rx_read_count++;
      chk_b("rx_read_single", prev_rx_read, 1'b0);
    end
    prev_rx_read = (RX_READ === 1'b1);
    if (rx_pop && rx_empty === 1'b0) begin
      chk_b("rx_pop_expected", rx_exp.size() != 0, 1'b1);
      if (rx_exp.size() != 0) chk_v("rx_data", rx_data, rx_exp.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    if (keep) tx_exp.push_back(b);
    tx_data = b; tx_push = 1'b1;
    tick(1);
    tx_push = 1'b0;
  endtask

  task automatic pop_one();
    rx_pop = 1'b1; tick(1); rx_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input bit keep, output int lat, output logic empty_after);
    int n = 0;
    if (keep) rx_exp.push_back(b);
    UART_RXD = b; RX_EFF = 1'b1;
    while (RX_READ !== 1'b1 && n < 10) begin tick(1); n++; end
    chk_b("rx_read_seen", RX_READ, 1'b1);
    lat = n;
    tick(1);
    empty_after = rx_empty;
    RX_EFF = 1'b0;
    tick(1);
  endtask

  task automatic wait_en(input int target, input int limit);
    int n = 0;
    while (en_cyc.size() < target && n < limit) begin tick(1); n++; end
    chk_b("tx_en_timeout", en_cyc.size() >= target, 1'b1);
  endtask

  task automatic wait_tx_idle(input int limit);
    int n = 0;
    while (tx_idle !== 1'b1 && n < limit) begin tick(1); n++; end
    chk_b("tx_idle_timeout", tx_idle, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_v({tag, "_uart_txd"}, UART_TXD, 8'h00);
    chk_b({tag, "_tx_en"}, TX_EN, 1'b0);
    chk_b({tag, "_rx_read"}, RX_READ, 1'b0);
    chk_b({tag, "_tx_drop"}, tx_drop, 1'b0);
    chk_b({tag, "_rx_ovf"}, rx_ovf, 1'b0);
    chk_b({tag, "_tx_full"}, tx_full, 1'b0);
    chk_b({tag, "_rx_empty"}, rx_empty, 1'b1);
    chk_b({tag, "_tx_idle"}, tx_idle, 1'b1);
    chk_v({tag, "_rx_data"}, rx_data, 8'h00);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, push_cyc, lat, gap, rc0;
    logic emp;

    tick(1);
    check_reset_vals("reset0");
    reset = 1'b0;
    tick(2);

    // Two bytes through a sender with 20-cycle busy time.
    base = en_cyc.size();
    push_cyc = cyc;
    push(8'h55, 1'b1);
    push(8'hAA, 1'b1);
    chk_b("tx_idle_busy", tx_idle, 1'b0);
    wait_en(base + 2, 200);
    chk_i("tx_en_latency", (en_cyc.size() > base) ? en_cyc[base] - push_cyc : -1, 2);
    wait_tx_idle(100);
    chk_b("tx_status_done", TX_STATUS, 1'b1);
    chk_v("uart_txd_held", UART_TXD, 8'hAA);

    // Sender held busy: fill, overflow, clear, clear-vs-set, push while popping a full FIFO.
    uart_mode = 1;
    tick(2);
    for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i), 1'b1);
    chk_b("tx_full_3", tx_full, 1'b0);
    push(8'hA4, 1'b1);
    chk_b("tx_full_4", tx_full, 1'b1);
    push(8'hE5, 1'b0);
    chk_b("tx_drop_set", tx_drop, 1'b1);
    chk_b("tx_full_keep", tx_full, 1'b1);
    pulse_clr();
    chk_b("tx_drop_clr", tx_drop, 1'b0);
    err_clr = 1'b1;
    push(8'hE6, 1'b0);
    err_clr = 1'b0;
    chk_b("tx_drop_set_wins", tx_drop, 1'b1);
    pulse_clr();
    chk_b("tx_drop_clr2", tx_drop, 1'b0);
    uart_mode = 2;
    push(8'hA5, 1'b1);
    uart_mode = 1;
    chk_b("full_pop_push_full", tx_full, 1'b1);
    chk_b("full_pop_push_nodrop", tx_drop, 1'b0);
    tick(3);
    uart_mode = 0;
    wait_tx_idle(600);

    // Five received bytes with no reads: four kept, fifth overflows.
    rc0 = rx_read_count;
    rx_send(8'h01, 1'b1, lat, emp);
    chk_i("rx_read_latency", lat, 1);
    chk_b("rx_empty_latency", emp, 1'b0);
    for (int i = 2; i <= 4; i++) rx_send(8'(i), 1'b1, lat, emp);
    chk_b("rx_ovf_before", rx_ovf, 1'b0);
    rx_send(8'h05, 1'b0, lat, emp);
    chk_i("rx_read_count", rx_read_count - rc0, 5);
    chk_b("rx_ovf_set", rx_ovf, 1'b1);
    for (int i = 0; i < 4; i++) pop_one();
    chk_b("rx_empty_drained", rx_empty, 1'b1);
    chk_v("rx_data_empty", rx_data, 8'h00);
    pop_one();
    chk_b("rx_pop_on_empty", rx_empty, 1'b1);
    pulse_clr();
    chk_b("rx_ovf_clr", rx_ovf, 1'b0);

    // Full RX FIFO: capture and pop in the same cycle.
    for (int i = 0; i < 4; i++) rx_send(8'h10 + 8'(i), 1'b1, lat, emp);
    rx_exp.push_back(8'h7E);
    UART_RXD = 8'h7E; RX_EFF = 1'b1;
    tick(1);
    chk_b("simul_rx_read", RX_READ, 1'b1);
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0; RX_EFF = 1'b0;
    tick(1);
    chk_b("simul_no_ovf", rx_ovf, 1'b0);
    for (int i = 0; i < 3; i++) pop_one();
    chk_b("simul_one_left", rx_empty, 1'b0);
    chk_v("simul_head", rx_data, 8'h7E);
    pop_one();
    chk_b("simul_empty", rx_empty, 1'b1);

    // Sender never reports busy: timeout, then the next byte is sent.
    uart_mode = 2;
    tick(2);
    base = en_cyc.size();
    push(8'h3C, 1'b1);
    push(8'hC3, 1'b1);
    wait_en(base + 2, 70000);
    gap = (en_cyc.size() > base + 1) ? en_cyc[base + 1] - en_cyc[base] : -1;
    chk_b("stuck_timeout_gap", gap >= 65535 && gap <= 65538, 1'b1);
    uart_mode = 1;
    tick(3);
    uart_mode = 0;
    wait_tx_idle(100);

    // Reset in WAIT_DONE with three bytes queued; inputs during reset are ignored.
    base = en_cyc.size();
    push(8'h91, 1'b1);
    push(8'h92, 1'b0);
    push(8'h93, 1'b0);
    push(8'h94, 1'b0);
    wait_en(base + 1, 50);
    tick(5);
    chk_b("pre_reset_busy", tx_idle, 1'b0);
    reset = 1'b1; tx_push = 1'b1; tx_data = 8'hEE; RX_EFF = 1'b1; UART_RXD = 8'h33;
    tick(1);
    check_reset_vals("reset_mid");
    reset = 1'b0; tx_push = 1'b0; RX_EFF = 1'b0;
    base = en_cyc.size();
    tick(40);
    chk_i("no_tx_after_reset", en_cyc.size() - base, 0);
    push(8'hB7, 1'b1);
    wait_en(base + 1, 50);
    wait_tx_idle(100);

    chk_i("tx_exp_left", tx_exp.size(), 0);
    chk_i("rx_exp_left", rx_exp.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving entries per FIFO (power of 2, 2..16).
REQ-002 The block SHALL have port sysclk, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port tx_push, input, 1 bit: host writes tx_data into TX FIFO this cycle.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte to transmit.
REQ-006 The block SHALL have port tx_full, output, 1 bit: TX FIFO holds DEPTH entries.
REQ-007 The block SHALL have port tx_idle, output, 1 bit: TX FIFO empty and TX FSM in IDLE.
REQ-008 The block SHALL have port rx_pop, input, 1 bit: host consumes rx_data this cycle.
REQ-009 The block SHALL have port rx_data, output, 8 bits: head of RX FIFO (show-ahead), 0x00 when empty.
REQ-010 The block SHALL have port rx_empty, output, 1 bit: RX FIFO holds no entries.
REQ-011 The block SHALL have port err_clr, input, 1 bit: clears sticky error flags.
REQ-012 The block SHALL have port tx_drop, output, 1 bit: sticky, push attempted while tx_full.
REQ-013 The block SHALL have port rx_ovf, output, 1 bit: sticky, received byte lost because RX FIFO full.
REQ-014 The block SHALL have port UART_TXD, output, 8 bits: byte presented to UART sender.
REQ-015 The block SHALL have port TX_EN, output, 1 bit: one-cycle send command to UART sender.
REQ-016 The block SHALL have port TX_STATUS, input, 1 bit: 1 = UART sender free.
REQ-017 The block SHALL have port UART_RXD, input, 8 bits: last byte received by the UART.
REQ-018 The block SHALL have port RX_EFF, input, 1 bit: 1 = UART_RXD unread.
REQ-019 The block SHALL have port RX_READ, output, 1 bit: one-cycle acknowledge clearing RX_EFF.

Function
REQ-020 The TX FIFO and the RX FIFO SHALL each be circular with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, plus a log2(DEPTH)+1-bit count.
REQ-021 A tx_push while not full SHALL store tx_data; a tx_push while full SHALL be ignored and SHALL set tx_drop the next cycle.
REQ-022 The TX FSM SHALL have states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-023 IDLE -> LOAD SHALL occur when the TX FIFO is non-empty and TX_STATUS=1; on this transition the head byte SHALL be registered onto UART_TXD and popped.
REQ-024 In LOAD, TX_EN SHALL be 1 for exactly that one cycle, followed by an unconditional move to WAIT_BUSY; UART_TXD SHALL be held stable from LOAD until the next LOAD.
REQ-025 WAIT_BUSY -> WAIT_DONE SHALL occur on TX_STATUS=0; WAIT_DONE -> IDLE SHALL occur on TX_STATUS=1.
REQ-026 A 16-bit counter in WAIT_BUSY SHALL force WAIT_BUSY -> IDLE after 65535 cycles without TX_STATUS=0, with no retry of the byte.
REQ-027 Simultaneous tx_push and internal pop on a full TX FIFO SHALL accept the push, leaving the count unchanged, with no tx_drop.
REQ-028 RX capture SHALL occur when RX_EFF=1, RX_READ=0 (registered) and not reset; in that case RX_READ SHALL be pulsed for 1 cycle.
REQ-029 On RX capture, UART_RXD SHALL be written if the RX FIFO is not full; otherwise the byte SHALL be discarded and rx_ovf set.
REQ-030 RX_READ SHALL never be asserted on two consecutive cycles.
REQ-031 rx_pop while empty SHALL be ignored.
REQ-032 Simultaneous capture and rx_pop SHALL both take effect, including when the RX FIFO is full, with no rx_ovf.
REQ-033 err_clr SHALL clear tx_drop and rx_ovf; a set event in the same cycle as err_clr SHALL win.
REQ-034 Latency SHALL be: tx_push at cycle t into an empty FIFO with TX_STATUS=1 gives TX_EN=1 at t+2; RX_EFF rising at t gives RX_READ=1 at t+1 and rx_empty=0 at t+2.

Reset
REQ-035 While reset=1 at a sysclk edge, the block SHALL clear all pointers and counts, set the FSM to IDLE, and clear the WAIT_BUSY counter.
REQ-036 The outputs after that reset edge SHALL be UART_TXD=0x00, TX_EN=0, RX_READ=0, tx_drop=0, rx_ovf=0, tx_full=0, rx_empty=1, tx_idle=1, rx_data=0x00.
REQ-037 Reset asserted mid-transfer SHALL abandon the current byte and all queued bytes, with no TX_EN pulse on the following cycle.
REQ-038 Inputs SHALL be ignored while reset=1.

Verification
REQ-039 The bench SHALL cover: push 0x55, 0xAA with TX_STATUS=1 modelled as 20-cycle busy after TX_EN -> two TX_EN pulses; UART_TXD=0x55 then 0xAA; tx_idle=1 after second TX_STATUS rise.
REQ-040 The bench SHALL cover: DEPTH=4, TX_STATUS held 0, push 5 bytes -> tx_full after 4th; 5th dropped; tx_drop=1; err_clr -> tx_drop=0.
REQ-041 The bench SHALL cover: RX_EFF pulses with bytes 0x01..0x05, no rx_pop -> five RX_READ pulses; FIFO holds 0x01..0x04; rx_ovf=1; pops return 0x01..0x04 then rx_empty=1.
REQ-042 The bench SHALL cover: TX_STATUS stuck 1 after TX_EN -> return to IDLE after 65535 cycles; next queued byte then sent.
REQ-043 The bench SHALL cover: reset during WAIT_DONE with 3 bytes queued -> the REQ-036 values next cycle; no TX_EN until a new push.
REQ-044 The bench SHALL cover: full RX FIFO, simultaneous capture of 0x7E and rx_pop -> count stays 4; rx_ovf=0; 0x7E last out.
